// File: rtl/uart_boot_loader.sv
// uart_boot_loader
// Parses framed load packets from the UART byte stream and writes the payload
// as 32-bit little-endian words through a simple memory write port. busy holds
// the core in reset while a packet is in progress.
//
// Packet: A5 | addr[7:0] .. addr[31:24] | N[7:0] N[15:8] | N*4 data bytes | csum
// The trailing checksum byte (XOR of every address, count and data byte) only
// exists when UART_BOOT_LOADER_CHECKSUM_EN is defined. Without it the packet
// ends after the last data word (or after the count when N=0) and always
// reports load_done; load_err is then raised only by the inter-byte timeout.
//
// Handshake: rx_data_valid is a one-cycle strobe with no backpressure; every
// cycle in which it is high delivers one byte on rx_data and that byte is
// consumed on the same rising edge. mem_we is a one-cycle strobe with no ready;
// mem_addr/mem_wdata are valid during that cycle.
//
// The FSM state (state_q) is a named enum register so it can be probed directly.

module uart_boot_loader #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_data_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);
    // The timeout fires on the edge that would take the idle counter to
    // TIMEOUT_CYCLES, i.e. when it currently holds TIMEOUT_CYCLES-1.
    localparam logic [31:0] TMO_LAST  = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3
    } state_t;
`endif

    // Parser state
    state_t              state_q,     state_d;
    logic [1:0]          byte_cnt_q,  byte_cnt_d;   // byte index within field / word
    logic [23:0]         addr_raw_q,  addr_raw_d;   // first three address bytes
    logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;    // address of the next word write
    logic [7:0]          len_lo_q,    len_lo_d;     // low byte of the word count
    logic [15:0]         words_left_q, words_left_d;
    logic [23:0]         word_q,      word_d;       // first three bytes of current word
    logic [31:0]         tmo_cnt_q,   tmo_cnt_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q,      csum_d;
`endif

    // Registered outputs
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                busy_q,      busy_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q,  load_err_d;

    // Assembled start address: full 32 bits, truncated to ADDR_W, word-aligned.
    logic [31:0]         addr_full;
    logic [ADDR_W-1:0]   addr_trunc;
    logic [ADDR_W-1:0]   addr_aligned;
    logic                tmo_fire;

    // Combine the fourth address byte with the three already collected.
    always_comb begin
        addr_full    = {rx_data, addr_raw_q};
        addr_trunc   = ADDR_W'(addr_full);
        addr_aligned = {addr_trunc[ADDR_W-1:2], 2'b00};
    end

    // Timeout: an accepted byte in the same cycle always wins over the timeout.
    always_comb begin
        tmo_fire = TMO_EN && (state_q != S_IDLE) && !rx_data_valid &&
                   (tmo_cnt_q == TMO_LAST);
    end

    // Next-state and registered-output logic for the packet parser.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        addr_raw_d   = addr_raw_q;
        wr_addr_d    = wr_addr_q;
        len_lo_d     = len_lo_q;
        words_left_d = words_left_q;
        word_d       = word_q;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        load_done_d  = 1'b0;
        load_err_d   = 1'b0;

        // Idle counter only runs inside a packet and clears on every byte.
        if (!TMO_EN || state_q == S_IDLE || rx_data_valid) begin
            tmo_cnt_d = 32'd0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end

        if (rx_data_valid) begin
            case (state_q)
                S_IDLE: begin
                    // Anything other than the sync byte is line noise.
                    if (rx_data == SYNC_BYTE) begin
                        state_d    = S_ADDR;
                        byte_cnt_d = 2'd0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                        csum_d     = 8'h00;
`endif
                    end
                end

                S_ADDR: begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    addr_raw_d = {rx_data, addr_raw_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_addr_d  = addr_aligned;
                        byte_cnt_d = 2'd0;
                        state_d    = S_LEN;
                    end
                end

                S_LEN: begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (byte_cnt_q == 2'd0) begin
                        len_lo_d   = rx_data;
                        byte_cnt_d = 2'd1;
                    end else begin
                        byte_cnt_d   = 2'd0;
                        words_left_d = {rx_data, len_lo_q};
                        if ({rx_data, len_lo_q} != 16'd0) begin
                            state_d = S_DATA;
                        end else begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d     = S_IDLE;
                            load_done_d = 1'b1;
`endif
                        end
                    end
                end

                S_DATA: begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    word_d     = {rx_data, word_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte completes the word: issue the write.
                        mem_we_d     = 1'b1;
                        mem_addr_d   = wr_addr_q;
                        mem_wdata_d  = {rx_data, word_q};
                        wr_addr_d    = wr_addr_q + ADDR_W'(4);
                        words_left_d = words_left_q - 16'd1;
                        if (words_left_q == 16'd1) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d     = S_IDLE;
                            load_done_d = 1'b1;
`endif
                        end
                    end
                end

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    // Writes already issued stay in memory regardless of result.
                    state_d = S_IDLE;
                    if (rx_data == csum_q) begin
                        load_done_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
`endif

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (tmo_fire) begin
            state_d    = S_IDLE;
            load_err_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= 2'd0;
            addr_raw_q   <= 24'd0;
            wr_addr_q    <= '0;
            len_lo_q     <= 8'd0;
            words_left_q <= 16'd0;
            word_q       <= 24'd0;
            tmo_cnt_q    <= 32'd0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_raw_q   <= addr_raw_d;
            wr_addr_q    <= wr_addr_d;
            len_lo_q     <= len_lo_d;
            words_left_q <= words_left_d;
            word_q       <= word_d;
            tmo_cnt_q    <= tmo_cnt_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    // Output ports come straight from registers.
    always_comb begin
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        busy      = busy_q;
        load_done = load_done_q;
        load_err  = load_err_q;
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader
// Directed packet sequence against uart_boot_loader (TIMEOUT_CYCLES=50).
// Expected writes are queued as each word's last byte is driven and popped
// when mem_we appears; load_done/load_err pulses are counted by the monitor.
// Follows the DUT build: define UART_BOOT_LOADER_CHECKSUM_EN for both.

module tb_uart_boot_loader;

    logic        clk;
    logic        rst;
    logic        rx_data_valid;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int          vectors;
    int          miscompares;
    int          done_cnt;
    int          err_cnt;
    int          exp_done;
    int          exp_err;

    logic [63:0] exp_q[$];
    logic [31:0] data_q[$];
    logic [63:0] mon_exp;

    uart_boot_loader #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_valid (rx_data_valid),
        .rx_data       (rx_data),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .load_done     (load_done),
        .load_err      (load_err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (load_done === 1'b1) done_cnt++;
        if (load_err === 1'b1)  err_cnt++;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 64'(mem_we), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("write_addr_data", {mem_addr, mem_wdata}, mon_exp);
            end
        end
    end

    // Drive one byte; returns 2 ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data_valid = 1'b1;
        rx_data       = b;
        @(posedge clk);
        #2;
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Full packet from data_q; gap = idle edges between consecutive bytes.
    task automatic send_packet(input logic [31:0] addr, input int gap, input bit bad_csum);
        logic [7:0]  csum;
        logic [7:0]  b;
        logic [15:0] n;
        logic [31:0] wa;
        logic [31:0] word;
        n    = 16'(data_q.size());
        csum = 8'h00;
        wa   = {addr[31:2], 2'b00};
        send_byte(8'hA5);
        check("busy_after_sync", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            b = addr[8*i +: 8];
            csum ^= b;
            idle(gap);
            send_byte(b);
            check("busy_in_addr", 64'(busy), 64'd1);
        end
        for (int i = 0; i < 2; i++) begin
            b = n[8*i +: 8];
            csum ^= b;
            idle(gap);
            send_byte(b);
        end
        for (int w = 0; w < int'(n); w++) begin
            word = data_q[w];
            for (int j = 0; j < 4; j++) begin
                b = word[8*j +: 8];
                csum ^= b;
                idle(gap);
                if (j == 3) exp_q.push_back({wa, word});
                send_byte(b);
                if (j == 3) begin
                    check("we_latency", 64'(mem_we), 64'd1);
                    wa += 32'd4;
                end
            end
        end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        idle(gap);
        send_byte(bad_csum ? (csum ^ 8'h01) : csum);
        if (bad_csum) exp_err++;
        else          exp_done++;
        check("load_done_pulse", 64'(load_done), 64'(!bad_csum));
        check("load_err_pulse", 64'(load_err), 64'(bad_csum));
`else
        exp_done++;
        check("load_done_pulse", 64'(load_done), 64'd1);
        check("load_err_pulse", 64'(load_err), 64'd0);
`endif
        check("busy_after_packet", 64'(busy), 64'd0);
    endtask

    // Settle, then compare pulse counters and confirm all writes arrived.
    task automatic settle_and_check(input string tag);
        idle(4);
        #2;
        check({tag, "_done_count"}, 64'(done_cnt), 64'(exp_done));
        check({tag, "_err_count"}, 64'(err_cnt), 64'(exp_err));
        check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int fire_at;
        vectors       = 0;
        miscompares   = 0;
        done_cnt      = 0;
        err_cnt       = 0;
        exp_done      = 0;
        exp_err       = 0;
        rst           = 1'b1;
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;

        // Reset state
        idle(3);
        #2;
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_load_err", 64'(load_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic load, two words, bytes with a small gap
        data_q = '{32'hDEADBEEF, 32'h12345678};
        send_packet(32'h0000_1000, 2, 1'b0);
        settle_and_check("basic");

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        // Bad checksum: writes still land, then load_err
        send_packet(32'h0000_1000, 0, 1'b1);
        settle_and_check("bad_csum");
`endif

        // Leading noise, unaligned address, sync value as payload
        send_byte(8'h00);
        check("noise_00_busy", 64'(busy), 64'd0);
        send_byte(8'hFF);
        check("noise_ff_busy", 64'(busy), 64'd0);
        data_q = '{32'hA5A5A5A5};
        send_packet(32'h0000_0003, 0, 1'b0);
        settle_and_check("noise_unaligned");

        // Zero-length packet
        data_q = {};
        send_packet(32'h0000_2000, 1, 1'b0);
        settle_and_check("zero_len");

        // Address wraps past the top of the address space
        data_q = '{32'hCAFEF00D, 32'h0BADC0DE};
        send_packet(32'hFFFF_FFFE, 0, 1'b0);
        settle_and_check("addr_wrap");

        // Timeout: silence after A5 and two address bytes
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        fire_at = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #2;
            if (load_err === 1'b1 && fire_at == 0) fire_at = c;
        end
        exp_err++;
        check("timeout_cycles", 64'(fire_at), 64'd50);
        check("timeout_busy", 64'(busy), 64'd0);
        settle_and_check("timeout");

        // Follow-up packet after the timeout loads normally
        data_q = '{32'h01020304};
        send_packet(32'h0000_0100, 0, 1'b0);
        settle_and_check("after_timeout");

        // Bytes arriving exactly on the timeout edge are accepted
        data_q = '{32'h55AA33CC};
        send_packet(32'h0000_4000, 49, 1'b0);
        settle_and_check("timeout_edge_byte");

        // Reset after the second data byte
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h30);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h44);
        send_byte(8'h33);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_mem_we", 64'(mem_we), 64'd0);
        check("midrst_mem_addr", 64'(mem_addr), 64'd0);
        check("midrst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_load_done", 64'(load_done), 64'd0);
        check("midrst_load_err", 64'(load_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        settle_and_check("mid_reset");
        data_q = '{32'h11223344};
        send_packet(32'h0000_3000, 0, 1'b0);
        settle_and_check("resend");

        // Random payload
        data_q = {};
        for (int i = 0; i < int'($urandom_range(6, 3)); i++) begin
            data_q.push_back($urandom);
        end
        send_packet($urandom, int'($urandom_range(3, 0)), 1'b0);
        settle_and_check("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
